// File: rtl/uart_fifo_ctrl_if.sv
// Port bundle between uart_fifo_ctrl (master) and its RX FIFO, TX FIFO and stopwatch (slave).
// Handshake: rx_pop/tx_push are single-cycle strobes; a pop is only issued while rx_empty=0 and
// rx_rdata is valid only in that cycle; a push is only issued while tx_full=0 and tx_wdata is valid with it.
interface uart_fifo_ctrl_if #(
    parameter int RPT_LEN = 8
);
    logic                   rx_empty;
    logic [7:0]             rx_rdata;
    logic                   rx_pop;
    logic                   tx_full;
    logic                   tx_push;
    logic [7:0]             tx_wdata;
    logic                   rpt_req;
    logic [8*RPT_LEN-1:0]   rpt_data;
    logic                   cmd_run_stop;
    logic                   cmd_clear;
    logic                   busy;
    logic [2:0]             dbg_state;

    modport master (
        input  rx_empty, rx_rdata, tx_full, rpt_req, rpt_data,
        output rx_pop, tx_push, tx_wdata, cmd_run_stop, cmd_clear, busy, dbg_state
    );

    modport slave (
        output rx_empty, rx_rdata, tx_full, rpt_req, rpt_data,
        input  rx_pop, tx_push, tx_wdata, cmd_run_stop, cmd_clear, busy, dbg_state
    );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// Drains the UART RX FIFO, decodes stopwatch commands, echoes bytes and
// serializes stopwatch time reports into the TX FIFO.
module uart_fifo_ctrl #(
    parameter int RPT_LEN = 8,
    parameter bit ECHO_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    uart_fifo_ctrl_if.master  bus
);
    localparam int IW = (RPT_LEN > 1) ? $clog2(RPT_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RX_POP = 3'd1,
        S_DECODE = 3'd2,
        S_ECHO   = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t               r_state;
    logic [7:0]           r_byte;
    logic [IW-1:0]        r_idx;
    logic [8*RPT_LEN-1:0] r_shadow;
    logic                 r_pending;

    logic                 w_is_run;
    logic                 w_is_clr;
    logic                 w_is_rpt;
    logic                 w_tx_phase;
    logic                 w_last;
    logic [8*RPT_LEN-1:0] w_shifted;
    logic [7:0]           w_wdata;

    assign w_is_run   = (r_byte == 8'h72) || (r_byte == 8'h52);
    assign w_is_clr   = (r_byte == 8'h63) || (r_byte == 8'h43);
    assign w_is_rpt   = (r_byte == 8'h74) || (r_byte == 8'h54);
    assign w_tx_phase = (r_state == S_ECHO) || (r_state == S_REPORT);
    assign w_last     = (r_idx == IW'(RPT_LEN - 1));

    // Byte 0 lives in the top byte of the shadow, so shift the selected byte up to the top.
    assign w_shifted  = r_shadow << {r_idx, 3'b000};

    always_comb begin
        w_wdata = 8'h00;
        if (r_state == S_ECHO) begin
            w_wdata = r_byte;
        end else if (r_state == S_REPORT) begin
            w_wdata = w_shifted[8*RPT_LEN-1 -: 8];
        end
    end

    assign bus.rx_pop       = (r_state == S_RX_POP);
    assign bus.tx_push      = w_tx_phase && !bus.tx_full;
    assign bus.tx_wdata     = w_wdata;
    assign bus.cmd_run_stop = (r_state == S_DECODE) && w_is_run;
    assign bus.cmd_clear    = (r_state == S_DECODE) && w_is_clr;
    assign bus.busy         = (r_state != S_IDLE) || r_pending;
    assign bus.dbg_state    = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_byte    <= 8'h00;
            r_idx     <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (bus.rpt_req || ((r_state == S_DECODE) && w_is_rpt)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    // Entering REPORT consumes the pending flag; a request on this same edge merges into it.
                    if (r_pending) begin
                        r_state   <= S_REPORT;
                        r_pending <= 1'b0;
                        r_shadow  <= bus.rpt_data;
                        r_idx     <= '0;
                    end else if (!bus.rx_empty) begin
                        r_state <= S_RX_POP;
                    end
                end
                S_RX_POP: begin
                    r_byte  <= bus.rx_rdata;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_state <= ECHO_EN ? S_ECHO : S_IDLE;
                end
                S_ECHO: begin
                    if (!bus.tx_full) begin
                        r_state <= S_IDLE;
                    end
                end
                S_REPORT: begin
                    if (!bus.tx_full) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_uart_fifo_ctrl;
    localparam int RPT_LEN = 8;
    localparam int W       = 18;
    localparam logic [1:0] K_POP  = 2'd0;
    localparam logic [1:0] K_CMDR = 2'd1;
    localparam logic [1:0] K_CMDC = 2'd2;
    localparam logic [1:0] K_PUSH = 2'd3;

    logic clk;
    logic rst;

    uart_fifo_ctrl_if #(.RPT_LEN(RPT_LEN)) bus();

    uart_fifo_ctrl #(.RPT_LEN(RPT_LEN), .ECHO_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected entry: {kind[1:0], data[7:0], gap[7:0]}; gap = cycles since previous event, 0 = any.
    logic [W-1:0] exp_q[$];
    logic [7:0]   rx_q[$];
    logic [7:0]   rx_head;
    logic         pop_flag = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           last_evt_cyc = 0;
    int           n_push = 0;
    int           n_pop = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- RX FIFO model ----------------
    assign bus.rx_rdata = bus.rx_pop ? rx_head : 8'hA5;

    initial begin
        bus.rx_empty = 1'b1;
        rx_head      = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (pop_flag && rx_q.size() > 0) rx_q.delete(0);
            bus.rx_empty = (rx_q.size() == 0);
            if (rx_q.size() > 0) rx_head = rx_q[0];
            else rx_head = 8'h00;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic observe(input logic [1:0] kind, input logic [7:0] data);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data %0h, expected none (cycle %0d)", kind, data, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e[17:16]));
            check("event_data", 32'(data), 32'(e[15:8]));
            if (e[7:0] != 8'd0) check("event_gap", 32'(cyc - last_evt_cyc), 32'(e[7:0]));
        end
        last_evt_cyc = cyc;
    endtask

    always @(negedge clk) begin
        cyc++;
        pop_flag = bus.rx_pop;
        if (bus.tx_push) check("push_while_full", 32'(bus.tx_full), 32'd0);
        if (bus.rx_pop) begin
            check("pop_while_empty", 32'(bus.rx_empty), 32'd0);
            check("pop_with_push", 32'(bus.tx_push), 32'd0);
            n_pop++;
            observe(K_POP, bus.rx_rdata);
        end
        if (bus.cmd_run_stop) observe(K_CMDR, 8'h00);
        if (bus.cmd_clear)    observe(K_CMDC, 8'h00);
        if (bus.tx_push) begin
            n_push++;
            observe(K_PUSH, bus.tx_wdata);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_evt(input logic [1:0] kind, input logic [7:0] data, input logic [7:0] gap);
        exp_q.push_back({kind, data, gap});
    endtask

    task automatic expect_report(input logic [8*RPT_LEN-1:0] bytes_v, input logic [7:0] first_gap);
        for (int i = 0; i < RPT_LEN; i++) begin
            expect_evt(K_PUSH, bytes_v[8*(RPT_LEN-1-i) +: 8], (i == 0) ? first_gap : 8'd1);
        end
    endtask

    task automatic pulse_rpt();
        bus.rpt_req = 1'b1;
        tick(1);
        bus.rpt_req = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int b;
        b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            tick(1);
            b--;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d events outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(6);
    endtask

    task automatic wait_count(input string name, input bit use_push, input int target, input int budget);
        int b;
        b = budget;
        while (((use_push ? n_push : n_pop) < target) && b > 0) begin
            tick(1);
            b--;
        end
        if ((use_push ? n_push : n_pop) < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d, expected %0d", name, use_push ? n_push : n_pop, target);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int base;
        rst          = 1'b0;
        bus.tx_full  = 1'b0;
        bus.rpt_req  = 1'b0;
        bus.rpt_data = '0;

        tick(2);
        check("rst_rx_pop", 32'(bus.rx_pop), 32'd0);
        check("rst_tx_push", 32'(bus.tx_push), 32'd0);
        check("rst_tx_wdata", 32'(bus.tx_wdata), 32'h00);
        check("rst_cmd_run", 32'(bus.cmd_run_stop), 32'd0);
        check("rst_cmd_clr", 32'(bus.cmd_clear), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        tick(1);
        rst = 1'b1;
        tick(20);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_no_pop", 32'(n_pop), 32'd0);

        // 'r': pop, run/stop pulse next cycle, echo the cycle after
        expect_evt(K_POP, 8'h72, 8'd0);
        expect_evt(K_CMDR, 8'h00, 8'd1);
        expect_evt(K_PUSH, 8'h72, 8'd1);
        rx_q.push_back(8'h72);
        drain("rx_r", 40);

        // 'C': clear pulse only
        expect_evt(K_POP, 8'h43, 8'd0);
        expect_evt(K_CMDC, 8'h00, 8'd1);
        expect_evt(K_PUSH, 8'h43, 8'd1);
        rx_q.push_back(8'h43);
        drain("rx_C", 40);

        // 'x': echo only
        expect_evt(K_POP, 8'h78, 8'd0);
        expect_evt(K_PUSH, 8'h78, 8'd2);
        rx_q.push_back(8'h78);
        drain("rx_x", 40);

        // Back-to-back 'c','R': one byte every 4 cycles
        expect_evt(K_POP, 8'h63, 8'd0);
        expect_evt(K_CMDC, 8'h00, 8'd1);
        expect_evt(K_PUSH, 8'h63, 8'd1);
        expect_evt(K_POP, 8'h52, 8'd2);
        expect_evt(K_CMDR, 8'h00, 8'd1);
        expect_evt(K_PUSH, 8'h52, 8'd1);
        rx_q.push_back(8'h63);
        rx_q.push_back(8'h52);
        drain("rx_pair", 60);

        // Back-pressure on echo
        base = n_push;
        bus.tx_full = 1'b1;
        expect_evt(K_POP, 8'h61, 8'd0);
        expect_evt(K_PUSH, 8'h61, 8'd0);
        rx_q.push_back(8'h61);
        wait_count("bp_pop", 1'b0, n_pop + 1, 40);
        tick(7);
        check("bp_no_push", 32'(n_push), 32'(base));
        check("bp_busy", 32'(bus.busy), 32'd1);
        bus.tx_full = 1'b0;
        drain("bp", 40);
        check("bp_one_push", 32'(n_push), 32'(base + 1));

        // Report, with rpt_data changed mid-report
        base = n_push;
        bus.rpt_data = "12:34.56";
        expect_report("12:34.56", 8'd0);
        pulse_rpt();
        check("rpt_busy", 32'(bus.busy), 32'd1);
        wait_count("rpt_mid", 1'b1, base + 3, 40);
        bus.rpt_data = '1;
        drain("rpt", 40);
        check("rpt_len", 32'(n_push), 32'(base + RPT_LEN));

        // Merge two requests during stalled echo, RX still non-empty
        base = n_push;
        bus.tx_full  = 1'b1;
        bus.rpt_data = "00:01.99";
        expect_evt(K_POP, 8'h61, 8'd0);
        expect_evt(K_PUSH, 8'h61, 8'd0);
        expect_report("00:01.99", 8'd2);
        expect_evt(K_POP, 8'h62, 8'd2);
        expect_evt(K_PUSH, 8'h62, 8'd2);
        rx_q.push_back(8'h61);
        rx_q.push_back(8'h62);
        wait_count("merge_pop", 1'b0, n_pop + 1, 40);
        pulse_rpt();
        tick(2);
        pulse_rpt();
        tick(2);
        bus.tx_full = 1'b0;
        drain("merge", 80);
        check("merge_pushes", 32'(n_push), 32'(base + RPT_LEN + 2));

        // 't': echo then full report
        bus.rpt_data = "98:76.54";
        expect_evt(K_POP, 8'h74, 8'd0);
        expect_evt(K_PUSH, 8'h74, 8'd2);
        expect_report("98:76.54", 8'd2);
        rx_q.push_back(8'h74);
        drain("rx_t", 60);

        // Reset after the 3rd report push
        base = n_push;
        bus.rpt_data = "12:34.56";
        for (int i = 0; i < 3; i++) expect_evt(K_PUSH, bus.rpt_data[8*(RPT_LEN-1-i) +: 8], (i == 0) ? 8'd0 : 8'd1);
        pulse_rpt();
        wait_count("rstm_push", 1'b1, base + 3, 40);
        rst = 1'b0;
        #1;
        check("rstm_push_drop", 32'(bus.tx_push), 32'd0);
        check("rstm_busy", 32'(bus.busy), 32'd0);
        tick(2);
        rst = 1'b1;
        tick(12);
        check("rstm_busy_after", 32'(bus.busy), 32'd0);
        check("rstm_no_more_push", 32'(n_push), 32'(base + 3));
        check("rstm_outstanding", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
Sequencer between the UART RX FIFO, the UART TX FIFO and the stopwatch core. It drains the RX FIFO one byte at a time, decodes stopwatch command characters into one-cycle command pulses, and echoes each byte into the TX FIFO. On request it also serializes a fixed-length time report from the stopwatch into the TX FIFO. It is the only agent popping the RX FIFO and the only agent pushing the TX FIFO, and it arbitrates TX FIFO push access between echo and report traffic.

Parameters:
RPT_LEN, 8, number of report bytes sent per report (e.g. ASCII "MM:SS.cc"); must be >= 1.
ECHO_EN, 1, 1 = echo every received byte to the TX FIFO; 0 = no echo, DECODE returns straight to IDLE.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
rx_empty  in  1  RX FIFO empty flag (registered in the FIFO).
rx_rdata  in  8  RX FIFO read data; valid only during the cycle rx_pop=1, high-Z otherwise.
rx_pop  out  1  RX FIFO pop strobe.
tx_full  in  1  TX FIFO full flag (registered in the FIFO).
tx_push  out  1  TX FIFO push strobe.
tx_wdata  out  8  TX FIFO write data.
rpt_req  in  1  one-cycle report request from the stopwatch.
rpt_data  in  8*RPT_LEN  report bytes; byte 0 = [8*RPT_LEN-1 -: 8], sent first.
cmd_run_stop  out  1  one-cycle pulse on 'r' or 'R'.
cmd_clear  out  1  one-cycle pulse on 'c' or 'C'.
busy  out  1  1 whenever state != IDLE or a report is pending.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; rx_pop=0, tx_push=0, tx_wdata=8'h00, cmd_run_stop=0, cmd_clear=0, busy=0; byte register, report index, report shadow and rpt_pending cleared. A report or echo in progress is abandoned, with no further push.
- States: IDLE, RX_POP, DECODE, ECHO, REPORT.
- rpt_pending: set on rpt_req=1 or on a decoded 't'/'T'; cleared on entering REPORT. A request that arrives while pending or in REPORT merges into the single pending flag; no queueing beyond one.
- IDLE: if rpt_pending -> REPORT. Else if rx_empty=0 -> RX_POP. Else stay. A pending report has priority over RX.
- REPORT entry: load the shadow register from rpt_data and set index=0. rpt_data is sampled only at this edge.
- RX_POP (1 cycle): rx_pop=1 (Moore output). Capture rx_rdata into the byte register at the end of this cycle. rx_pop is never asserted when the last-sampled rx_empty=1. Next state: DECODE.
- DECODE (1 cycle): drive cmd_run_stop for 'r' (8'h72) or 'R' (8'h52), and cmd_clear for 'c' (8'h63) or 'C' (8'h43). For 't' (8'h74) or 'T' (8'h54), set rpt_pending. Any other byte produces no command. Next state: ECHO if ECHO_EN=1, else IDLE.
- Command pulses are combinational from state and byte, and last exactly one cycle.
- ECHO: tx_wdata=byte. tx_push = ~tx_full, combinational. Stay in ECHO while tx_full=1. On the push cycle -> IDLE.
- REPORT: tx_wdata=shadow byte[index]. tx_push = ~tx_full. On each push, index increments. The push with index=RPT_LEN-1 -> IDLE. While tx_full=1, hold index and push nothing.
- tx_push is never 1 while tx_full=1. rx_pop and tx_push are never both generated by the RX and report paths in the same cycle.
- Latency (ECHO_EN=1, TX not full, no pending report): IDLE with rx_empty=0 at cycle k -> rx_pop at k+1 -> command pulse at k+2 -> tx_push with echo byte at k+3 -> IDLE at k+4. Throughput is one byte per 4 cycles.
- Report length: exactly RPT_LEN pushes when TX never fills. Each full cycle adds one stall cycle.
- index width: clog2(RPT_LEN), minimum 1 bit.
- A 't' decoded during DECODE is reported after its echo completes.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then rst=1 with rx_empty=1 -> all outputs 0, busy=0, no rx_pop in 20 cycles.
- RX 'r': rx_empty falls with rx_rdata=8'h72 at pop -> rx_pop 1 cycle, then cmd_run_stop 1 cycle, then tx_push with tx_wdata=8'h72 one cycle later. 'C' (8'h43) -> cmd_clear only. 'x' -> echo only, no pulse.
- Back-pressure: tx_full=1 during ECHO for 5 cycles -> tx_push=0 for those cycles, then one push of the byte; exactly one push total.
- Report: rpt_req pulse with rpt_data="12:34.56", RPT_LEN=8 -> 8 consecutive pushes of 8'h31,8'h32,8'h3A,8'h33,8'h34,8'h2E,8'h35,8'h36. rpt_data changed mid-report does not affect output.
- Priority/merge: rpt_req while an ECHO is stalled, plus a second rpt_req, with RX non-empty -> echo finishes, one report sent, then RX pop resumes. 't' received -> echo 8'h74 then full report.
- Reset mid-report: rst=0 after the 3rd report push -> tx_push drops immediately, no further pushes, pending cleared, busy=0 after release.
